pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter MDU_CYCLES, default 32, meaning the ID-stage hold length for a multiply/divide, legal range 2..255.
REQ-002 SHALL have parameter CNT_BITS, default 16, meaning the width of the stall-cycle counter.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port id_valid  input  1  ID stage holds a real instruction.
REQ-006 SHALL have ports id_rs, id_rt  input  5 each  ID source register numbers.
REQ-007 SHALL have ports id_use_rs, id_use_rt  input  1 each  ID actually reads rs/rt.
REQ-008 SHALL have port id_mdu  input  1  ID instruction is multiply/divide.
REQ-009 SHALL have port id_syscall  input  1  ID instruction is halt/syscall.
REQ-010 SHALL have ports ex_memread, ex_valid  input  1 each  EX holds a valid load.
REQ-011 SHALL have port ex_rd  input  5  EX destination register.
REQ-012 SHALL have port ex_branch_taken  input  1  EX resolved a taken branch/jump.
REQ-013 SHALL have port pc_en  output  1  PC loads next value.
REQ-014 SHALL have port if_id_load  output  1  IF/ID register loads new PC/IR.
REQ-015 SHALL have port if_id_zero  output  1  IF/ID register clears to bubble.
REQ-016 SHALL have port id_ex_zero  output  1  ID/EX register clears to bubble.
REQ-017 SHALL have port halted  output  1  core halted.
REQ-018 SHALL have port stall_cnt  output  CNT_BITS  cycles with pc_en=0 while not halted.

Function
REQ-019 SHALL implement states RUN, MDU_WAIT, HALT; state, MDU counter and stall_cnt registered; pc_en/if_id_load/if_id_zero/id_ex_zero combinational from state and current inputs.
REQ-020 SHALL define load_use = id_valid & ex_valid & ex_memread & ex_rd!=0 & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)).
REQ-021 In RUN with ex_branch_taken=1: pc_en=1, if_id_load=0, if_id_zero=1, id_ex_zero=1; state stays RUN; overrides load_use, id_mdu, id_syscall in the same cycle.
REQ-022 In RUN, no branch, load_use=1: pc_en=0, if_id_load=0, if_id_zero=0, id_ex_zero=1 (one bubble); next cycle re-evaluates normally.
REQ-023 In RUN, no branch, no load_use, id_valid & id_syscall: pc_en=0, if_id_load=0, id_ex_zero=1, if_id_zero=0; next state HALT.
REQ-024 In RUN, no branch, no load_use, id_valid & id_mdu & !id_syscall: pc_en=0, if_id_load=0, id_ex_zero=1; counter loads MDU_CYCLES-1; next state MDU_WAIT.
REQ-025 In RUN otherwise: pc_en=1, if_id_load=1, if_id_zero=0, id_ex_zero=0.
REQ-026 In MDU_WAIT, counter!=0: pc_en=0, if_id_load=0, id_ex_zero=1, counter decrements; ex_branch_taken ignored (EX holds a bubble).
REQ-027 In MDU_WAIT, counter==0: outputs as REQ-025 (MDU instruction advances to EX), next state RUN; total ID hold = MDU_CYCLES cycles.
REQ-028 In HALT: pc_en=0, if_id_load=0, if_id_zero=1, id_ex_zero=1, halted=1; exits only via rst_n.
REQ-029 stall_cnt SHALL increment on each clock edge where pc_en=0 and state!=HALT, saturating at all-ones (no wrap).
REQ-030 halted SHALL be 1 only in HALT.

Reset
REQ-031 rst_n=0 SHALL immediately (asynchronously) force state RUN, counter 0, stall_cnt 0, halted 0, pc_en 0, if_id_load 0, if_id_zero 1, id_ex_zero 1.
REQ-032 Reset asserted in MDU_WAIT or HALT SHALL abandon the operation; first cycle after rst_n rises SHALL behave as RUN per REQ-021..025.

Verification
REQ-033 Load-use: ex_memread=1, ex_valid=1, ex_rd=5, id_rs=5, id_use_rs=1 -> one cycle pc_en=0, id_ex_zero=1; next cycle pc_en=1; stall_cnt=1.
REQ-034 ex_rd=0 with otherwise matching load-use -> no stall, pc_en=1, stall_cnt unchanged.
REQ-035 ex_branch_taken=1 coincident with load_use and id_mdu -> if_id_zero=1, id_ex_zero=1, pc_en=1, state stays RUN.
REQ-036 id_mdu=1, MDU_CYCLES=4 -> pc_en=0 for exactly 4 cycles, id_ex_zero=1 those cycles, fifth cycle pc_en=1, stall_cnt=4.
REQ-037 id_syscall=1 -> halted=1 next cycle and held 100 cycles, stall_cnt frozen; rst_n pulse low -> halted=0, stall_cnt=0.
REQ-038 CNT_BITS=4, 20 consecutive load-use cycles -> stall_cnt reaches 15 and stays 15.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Hazard/stall controller for a 5-stage in-order pipeline: load-use bubbles, branch flushes, MDU hold, halt.
// Enables and zero controls are combinational from state and current inputs; state, MDU counter and stall count are registered.
module pipeline_ctrl #(
    parameter int MDU_CYCLES = 32,
    parameter int CNT_BITS   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic [4:0]          id_rs,
    input  logic [4:0]          id_rt,
    input  logic                id_use_rs,
    input  logic                id_use_rt,
    input  logic                id_mdu,
    input  logic                id_syscall,
    input  logic                ex_memread,
    input  logic                ex_valid,
    input  logic [4:0]          ex_rd,
    input  logic                ex_branch_taken,
    output logic                pc_en,
    output logic                if_id_load,
    output logic                if_id_zero,
    output logic                id_ex_zero,
    output logic                halted,
    output logic [CNT_BITS-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MDU_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    localparam logic [7:0] MDU_LOAD = 8'(MDU_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] mdu_cnt;
    logic [7:0] mdu_cnt_nxt;
    logic       rs_hit;
    logic       rt_hit;
    logic       load_use;

    assign rs_hit   = id_use_rs && (id_rs == ex_rd);
    assign rt_hit   = id_use_rt && (id_rt == ex_rd);
    assign load_use = id_valid && ex_valid && ex_memread && (ex_rd != 5'd0) && (rs_hit || rt_hit);

    assign halted = (state == HALT);

    // Defaults are the flushed/frozen pattern, which is also what reset must show immediately.
    always_comb begin
        pc_en       = 1'b0;
        if_id_load  = 1'b0;
        if_id_zero  = 1'b1;
        id_ex_zero  = 1'b1;
        state_nxt   = state;
        mdu_cnt_nxt = mdu_cnt;
        if (rst_n) begin
            case (state)
                RUN: begin
                    if (ex_branch_taken) begin
                        pc_en = 1'b1;
                    end else if (load_use) begin
                        if_id_zero = 1'b0;
                    end else if (id_valid && id_syscall) begin
                        if_id_zero = 1'b0;
                        state_nxt  = HALT;
                    end else if (id_valid && id_mdu) begin
                        if_id_zero  = 1'b0;
                        mdu_cnt_nxt = MDU_LOAD;
                        state_nxt   = MDU_WAIT;
                    end else begin
                        pc_en      = 1'b1;
                        if_id_load = 1'b1;
                        if_id_zero = 1'b0;
                        id_ex_zero = 1'b0;
                    end
                end
                MDU_WAIT: begin
                    // EX holds a bubble here, so a taken-branch indication cannot be genuine.
                    if (mdu_cnt != 8'd0) begin
                        if_id_zero  = 1'b0;
                        mdu_cnt_nxt = mdu_cnt - 8'd1;
                    end else begin
                        pc_en      = 1'b1;
                        if_id_load = 1'b1;
                        if_id_zero = 1'b0;
                        id_ex_zero = 1'b0;
                        state_nxt  = RUN;
                    end
                end
                HALT: begin
                    state_nxt = HALT;
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            mdu_cnt   <= 8'd0;
            stall_cnt <= '0;
        end else begin
            state   <= state_nxt;
            mdu_cnt <= mdu_cnt_nxt;
            if (!pc_en && (state != HALT) && (stall_cnt != {CNT_BITS{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed hazard scenarios then randomized traffic against a cycle-level model.
module tb_pipeline_ctrl;

    localparam int MDU      = 4;
    localparam int CNT_BITS = 4;
    localparam int CNT_MAX  = (1 << CNT_BITS) - 1;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                id_valid = 1'b0;
    logic [4:0]          id_rs = 5'd0;
    logic [4:0]          id_rt = 5'd0;
    logic                id_use_rs = 1'b0;
    logic                id_use_rt = 1'b0;
    logic                id_mdu = 1'b0;
    logic                id_syscall = 1'b0;
    logic                ex_memread = 1'b0;
    logic                ex_valid = 1'b0;
    logic [4:0]          ex_rd = 5'd0;
    logic                ex_branch_taken = 1'b0;
    logic                pc_en;
    logic                if_id_load;
    logic                if_id_zero;
    logic                id_ex_zero;
    logic                halted;
    logic [CNT_BITS-1:0] stall_cnt;

    pipeline_ctrl #(.MDU_CYCLES(MDU), .CNT_BITS(CNT_BITS)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_mdu(id_mdu), .id_syscall(id_syscall),
        .ex_memread(ex_memread), .ex_valid(ex_valid), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken),
        .pc_en(pc_en), .if_id_load(if_id_load), .if_id_zero(if_id_zero),
        .id_ex_zero(id_ex_zero), .halted(halted), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic                pc_en;
        logic                if_id_load;
        logic                if_id_zero;
        logic                id_ex_zero;
        logic                halted;
        logic [CNT_BITS-1:0] stall_cnt;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // Model: halted flag, "ID held by a multiply/divide for held cycles so far", stall count.
    bit m_halt = 1'b0;
    bit m_mdu  = 1'b0;
    int m_held = 0;
    int m_stall = 0;

    task automatic cyc(input string tag, input logic rst, input logic v,
                       input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                       input logic mdu, input logic sys, input logic exm, input logic exv,
                       input logic [4:0] exrd, input logic br);
        exp_t e;
        logic lu;
        bit   was_halt;
        @(posedge clk);
        #1;
        rst_n = rst; id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_mdu = mdu; id_syscall = sys; ex_memread = exm; ex_valid = exv; ex_rd = exrd;
        ex_branch_taken = br;
        lu = v && exm && exv && (exrd != 5'd0) && ((urs && rs == exrd) || (urt && rt == exrd));
        if (!rst) begin
            m_halt = 1'b0; m_mdu = 1'b0; m_held = 0; m_stall = 0;
        end
        was_halt = m_halt;
        e = '0;
        e.if_id_zero = 1'b1;
        e.id_ex_zero = 1'b1;
        if (!rst || m_halt) begin
            e.halted = m_halt;
        end else if (m_mdu) begin
            if (m_held < MDU) begin
                e.if_id_zero = 1'b0;
                m_held++;
            end else begin
                e = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0};
                m_mdu = 1'b0;
            end
        end else if (br) begin
            e.pc_en = 1'b1;
        end else if (lu) begin
            e.if_id_zero = 1'b0;
        end else if (v && sys) begin
            e.if_id_zero = 1'b0;
            m_halt = 1'b1;
        end else if (v && mdu) begin
            e.if_id_zero = 1'b0;
            m_mdu = 1'b1;
            m_held = 1;
        end else begin
            e = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0};
        end
        e.stall_cnt = CNT_BITS'(m_stall);
        if (rst && !was_halt && !e.pc_en && m_stall < CNT_MAX)
            m_stall++;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++)
            cyc(tag, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic load_use_cyc(input string tag);
        cyc(tag, 1, 1, 5, 0, 1, 0, 0, 0, 1, 1, 5, 0);
    endtask

    // Monitor: outputs are valid every cycle; sample mid-cycle, away from the rising edge.
    initial begin
        exp_t  e;
        exp_t  a;
        string t;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                a = '{pc_en, if_id_load, if_id_zero, id_ex_zero, halted, stall_cnt};
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL %s @%0t: got pc_en=%b load=%b ifz=%b exz=%b halted=%b cnt=%0d, expected pc_en=%b load=%b ifz=%b exz=%b halted=%b cnt=%0d",
                             t, $time, a.pc_en, a.if_id_load, a.if_id_zero, a.id_ex_zero, a.halted, a.stall_cnt,
                             e.pc_en, e.if_id_load, e.if_id_zero, e.id_ex_zero, e.halted, e.stall_cnt);
                end
            end
        end
    end

    initial begin
        cyc("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("reset_hold", 0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1);
        idle("run", 2);
        load_use_cyc("load_use");
        idle("after_load_use", 2);
        cyc("rd_zero", 1, 1, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0);
        cyc("rt_hit", 1, 1, 0, 7, 0, 1, 0, 0, 1, 1, 7, 0);
        cyc("rt_unused", 1, 1, 0, 7, 0, 0, 0, 0, 1, 1, 7, 0);
        cyc("not_load", 1, 1, 7, 0, 1, 0, 0, 0, 0, 1, 7, 0);
        cyc("branch_over_all", 1, 1, 5, 0, 1, 0, 1, 1, 1, 1, 5, 1);
        idle("after_branch", 1);
        cyc("mdu_start", 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        cyc("mdu_wait_branch", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle("mdu_wait", 4);
        cyc("mdu_reset", 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        idle("mdu_reset_wait", 1);
        cyc("mdu_abort", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle("after_abort", 2);
        cyc("syscall", 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 100; i++)
            cyc("halt_hold", 1, 1, 5, 5, 1, 1, $urandom_range(0, 1), $urandom_range(0, 1), 1, 1, 5, $urandom_range(0, 1));
        cyc("halt_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle("after_halt", 2);
        for (int i = 0; i < 20; i++)
            load_use_cyc("saturate");
        idle("saturated", 2);

        for (int i = 0; i < 3000; i++) begin
            logic rst;
            rst = m_halt ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 59) != 0);
            cyc("random", rst, $urandom_range(0, 3) != 0,
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0,
                $urandom_range(0, 1), $urandom_range(0, 3) != 0,
                5'($urandom_range(0, 3)), $urandom_range(0, 7) == 0);
        end

        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected responses left unchecked, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
